// File: rtl/vga_stream_timing_gen_if.sv
// Pixel-domain bundle between the camera FIFO read side, the timing
// generator and the video encoder.
interface vga_stream_timing_gen_if #(
    parameter int DATA_W = 16
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data_in;
    logic              fifo_read_en;
    logic              hsync;
    logic              vsync;
    logic              dataEnable;
    logic [23:0]       RGBchannel;
    logic [11:0]       pixel_x;
    logic [11:0]       pixel_y;
    logic              frame_start;
    logic [15:0]       underflow_count;
    logic              sync_lost;

    // Timing generator side: consumes FIFO head, drives video.
    modport master (
        input  fifo_empty, fifo_data_in,
        output fifo_read_en, hsync, vsync, dataEnable, RGBchannel,
               pixel_x, pixel_y, frame_start, underflow_count, sync_lost
    );

    // Environment side: FIFO plus encoder.
    modport slave (
        output fifo_empty, fifo_data_in,
        input  fifo_read_en, hsync, vsync, dataEnable, RGBchannel,
               pixel_x, pixel_y, frame_start, underflow_count, sync_lost
    );
endinterface

// File: rtl/vga_stream_timing_gen.sv
// Display-timing generator and pixel streamer. Pops RGB565/RGB888 words
// from a first-word-fall-through FIFO during the visible region, flags and
// counts underflows, and re-aligns to the next frame boundary after a bad
// frame so the FIFO content and the raster never stay out of step.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_STARTUP  | blank output while the camera settles, counting frames
// ST_ALIGN    | blank output, waiting for a frame boundary with FIFO data
// ST_STREAM   | visible pixels taken from the FIFO, underflows painted/counted
//
// The ALIGN frame counts as one of the blank start-up frames, so with
// STARTUP_FRAMES=N streaming begins on frame N+1 (N>=1).
module vga_stream_timing_gen #(
    parameter int          H_ACTIVE        = 640,
    parameter int          H_FP            = 16,
    parameter int          H_SYNC          = 96,
    parameter int          H_BP            = 48,
    parameter int          V_ACTIVE        = 480,
    parameter int          V_FP            = 10,
    parameter int          V_SYNC          = 2,
    parameter int          V_BP            = 33,
    parameter bit          SYNC_POL        = 1'b0,
    parameter int          PIX_FMT         = 0,
    parameter int          DATA_W          = 16,
    parameter int          STARTUP_FRAMES  = 1,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF0000
) (
    input logic                     clock,
    input logic                     reset,
    vga_stream_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_BEGIN = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEGIN = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    // Frame index on which STARTUP hands over to ALIGN (see table note).
    localparam logic [7:0] SU_LAST = (STARTUP_FRAMES > 1) ? 8'(STARTUP_FRAMES - 2) : 8'd0;

    localparam logic [1:0] ST_STARTUP = 2'd0;
    localparam logic [1:0] ST_ALIGN   = 2'd1;
    localparam logic [1:0] ST_STREAM  = 2'd2;

    logic [11:0]       h_cnt;
    logic [11:0]       v_cnt;
    logic [1:0]        state;
    logic [7:0]        frame_cnt;
    logic              frame_bad;
    logic [15:0]       uf_cnt;
    logic              lost;
    logic              hsync_q;
    logic              vsync_q;
    logic              de_q;
    logic [23:0]       rgb_q;
    logic              fs_q;
    logic [DATA_W-1:0] head;
    logic [23:0]       pix_rgb;

    logic h_last;
    logic frame_end;
    logic visible;
    logic hs_active;
    logic vs_active;
    logic streaming;
    logic pop;
    logic underflow;

    assign head      = bus.fifo_data_in;
    assign h_last    = (h_cnt == H_LAST);
    assign frame_end = h_last && (v_cnt == V_LAST);
    assign visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_active = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
    assign vs_active = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
    assign streaming = (state == ST_STREAM);
    assign pop       = streaming && visible && !bus.fifo_empty;
    assign underflow = streaming && visible && bus.fifo_empty;

    // Expand the FIFO head to {R8,G8,B8}; RGB565 fields are left-aligned, zero-filled.
    generate
        if (PIX_FMT == 0) begin : g_rgb565
            assign pix_rgb = {head[15:11], 3'b000, head[10:5], 2'b00, head[4:0], 3'b000};
        end else begin : g_rgb888
            assign pix_rgb = head[23:0];
        end
    endgenerate

    // Raster position: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Sequencing FSM; every state change happens on the last pixel of a frame
    // except the immediate STARTUP exit when no extra start-up frames are wanted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_STARTUP;
            frame_cnt <= '0;
            frame_bad <= 1'b0;
        end else begin
            case (state)
                ST_STARTUP: begin
                    if (STARTUP_FRAMES <= 1) begin
                        state <= ST_ALIGN;
                    end else if (frame_end) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        if (frame_cnt == SU_LAST) begin
                            state <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (frame_end && !bus.fifo_empty) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (underflow) begin
                        frame_bad <= 1'b1;
                    end
                    if (frame_end && frame_bad) begin
                        state     <= ST_ALIGN;
                        frame_bad <= 1'b0;
                    end
                end
                default: state <= ST_STARTUP;
            endcase
        end
    end

    // Underflow statistics: saturating pixel count and a sticky loss flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uf_cnt <= '0;
            lost   <= 1'b0;
        end else if (underflow) begin
            lost <= 1'b1;
            if (uf_cnt != 16'hFFFF) begin
                uf_cnt <= uf_cnt + 16'd1;
            end
        end
    end

    // Video outputs, all registered from the same raster position (one clock behind it).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= hs_active ? SYNC_POL : ~SYNC_POL;
            vsync_q <= vs_active ? SYNC_POL : ~SYNC_POL;
            de_q    <= visible;
            fs_q    <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
            if (pop) begin
                rgb_q <= pix_rgb;
            end else if (underflow) begin
                rgb_q <= UNDERFLOW_COLOR;
            end else begin
                rgb_q <= '0;
            end
        end
    end

    assign bus.fifo_read_en    = pop;
    assign bus.hsync           = hsync_q;
    assign bus.vsync           = vsync_q;
    assign bus.dataEnable      = de_q;
    assign bus.RGBchannel      = rgb_q;
    assign bus.pixel_x         = h_cnt;
    assign bus.pixel_y         = v_cnt;
    assign bus.frame_start     = fs_q;
    assign bus.underflow_count = uf_cnt;
    assign bus.sync_lost       = lost;
endmodule

// File: tb/tb_vga_stream_timing_gen.sv
// Directed bench for vga_stream_timing_gen: small 16x8 raster for timing,
// start-up, conversion, underflow and reset cases, a second instance for
// RGB888 with active-high sync, and a large raster for count saturation.
module tb_vga_stream_timing_gen;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    logic rst2;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vga_stream_timing_gen_if #(.DATA_W(16)) b0 ();
    vga_stream_timing_gen_if #(.DATA_W(24)) b1 ();
    vga_stream_timing_gen_if #(.DATA_W(16)) b2 ();

    vga_stream_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .SYNC_POL(1'b0), .PIX_FMT(0), .DATA_W(16), .STARTUP_FRAMES(2),
        .UNDERFLOW_COLOR(24'hFF0000)
    ) dut0 (.clock(clk), .reset(rst0), .bus(b0));

    vga_stream_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .SYNC_POL(1'b1), .PIX_FMT(1), .DATA_W(24), .STARTUP_FRAMES(0),
        .UNDERFLOW_COLOR(24'hFF0000)
    ) dut1 (.clock(clk), .reset(rst1), .bus(b1));

    vga_stream_timing_gen #(
        .H_ACTIVE(256), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(256), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .PIX_FMT(0), .DATA_W(16), .STARTUP_FRAMES(0),
        .UNDERFLOW_COLOR(24'hFF0000)
    ) dut2 (.clock(clk), .reset(rst2), .bus(b2));

    // Release dut0 reset on a falling edge: that instant is sample 0.
    task automatic rel0();
        rst0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b0;
    endtask

    task automatic test_reset();
        b0.fifo_empty   = 1'b1;
        b0.fifo_data_in = 16'h0000;
        rst0 = 1'b1;
        @(negedge clk);
        n_cmp++; if (b0.hsync !== 1'b1) begin n_bad++; $display("FAIL reset_hsync got %b want 1", b0.hsync); end
        n_cmp++; if (b0.vsync !== 1'b1) begin n_bad++; $display("FAIL reset_vsync got %b want 1", b0.vsync); end
        n_cmp++; if (b0.dataEnable !== 1'b0) begin n_bad++; $display("FAIL reset_de got %b want 0", b0.dataEnable); end
        n_cmp++; if (b0.RGBchannel !== 24'h0) begin n_bad++; $display("FAIL reset_rgb got %h want 0", b0.RGBchannel); end
        n_cmp++; if (b0.frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got %b want 0", b0.frame_start); end
        n_cmp++; if (b0.fifo_read_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd got %b want 0", b0.fifo_read_en); end
        n_cmp++; if (b0.underflow_count !== 16'h0) begin n_bad++; $display("FAIL reset_uf got %h want 0", b0.underflow_count); end
        n_cmp++; if (b0.sync_lost !== 1'b0) begin n_bad++; $display("FAIL reset_lost got %b want 0", b0.sync_lost); end
        n_cmp++; if (b0.pixel_x !== 12'd0) begin n_bad++; $display("FAIL reset_x got %0d want 0", b0.pixel_x); end
        n_cmp++; if (b0.pixel_y !== 12'd0) begin n_bad++; $display("FAIL reset_y got %0d want 0", b0.pixel_y); end
    endtask

    // One blank frame: 16 clk lines, 8 lines, sync low h=10..12 and v=5.
    task automatic test_timing();
        int de_hi = 0;
        int hs_lo = 0;
        int vs_lo = 0;
        b0.fifo_empty = 1'b1;
        rel0();
        for (int k = 1; k <= 128; k++) begin
            int p;
            int h;
            int v;
            logic e_de;
            logic e_hs;
            logic e_vs;
            @(negedge clk);
            p = k - 1;
            h = p % 16;
            v = p / 16;
            e_de = (h < 8) && (v < 4);
            e_hs = !((h >= 10) && (h < 13));
            e_vs = (v != 5);
            if (b0.dataEnable === 1'b1) de_hi++;
            if (b0.hsync === 1'b0) hs_lo++;
            if (b0.vsync === 1'b0) vs_lo++;
            n_cmp++; if (b0.dataEnable !== e_de) begin n_bad++; $display("FAIL tim_de k=%0d got %b want %b", k, b0.dataEnable, e_de); end
            n_cmp++; if (b0.hsync !== e_hs) begin n_bad++; $display("FAIL tim_hs k=%0d got %b want %b", k, b0.hsync, e_hs); end
            n_cmp++; if (b0.vsync !== e_vs) begin n_bad++; $display("FAIL tim_vs k=%0d got %b want %b", k, b0.vsync, e_vs); end
            n_cmp++; if (b0.frame_start !== (p == 0)) begin n_bad++; $display("FAIL tim_fs k=%0d got %b", k, b0.frame_start); end
            n_cmp++; if (b0.pixel_x !== 12'(k % 16)) begin n_bad++; $display("FAIL tim_x k=%0d got %0d want %0d", k, b0.pixel_x, k % 16); end
            n_cmp++; if (b0.pixel_y !== 12'((k / 16) % 8)) begin n_bad++; $display("FAIL tim_y k=%0d got %0d want %0d", k, b0.pixel_y, (k / 16) % 8); end
            n_cmp++; if (b0.fifo_read_en !== 1'b0 || b0.RGBchannel !== 24'h0) begin n_bad++; $display("FAIL tim_blank k=%0d rd %b rgb %h want 0/0", k, b0.fifo_read_en, b0.RGBchannel); end
        end
        n_cmp++; if (de_hi != 32) begin n_bad++; $display("FAIL tim_de_count got %0d want 32", de_hi); end
        n_cmp++; if (hs_lo != 24) begin n_bad++; $display("FAIL tim_hs_count got %0d want 24", hs_lo); end
        n_cmp++; if (vs_lo != 16) begin n_bad++; $display("FAIL tim_vs_count got %0d want 16", vs_lo); end
    endtask

    // FIFO always full: frames 1-2 blank, frame 3 pops every visible pixel.
    task automatic test_startup();
        int pops [3] = '{0, 0, 0};
        b0.fifo_empty   = 1'b0;
        b0.fifo_data_in = 16'hF800;
        rel0();
        for (int k = 0; k < 384; k++) begin
            int p;
            logic e_rd;
            p = k % 128;
            e_rd = (k >= 256) && ((p % 16) < 8) && ((p / 16) < 4);
            if (b0.fifo_read_en === 1'b1) pops[k / 128]++;
            n_cmp++; if (b0.fifo_read_en !== e_rd) begin n_bad++; $display("FAIL su_rd k=%0d got %b want %b", k, b0.fifo_read_en, e_rd); end
            @(negedge clk);
        end
        n_cmp++; if (pops[0] != 0) begin n_bad++; $display("FAIL su_pops_f1 got %0d want 0", pops[0]); end
        n_cmp++; if (pops[1] != 0) begin n_bad++; $display("FAIL su_pops_f2 got %0d want 0", pops[1]); end
        n_cmp++; if (pops[2] != 32) begin n_bad++; $display("FAIL su_pops_f3 got %0d want 32", pops[2]); end
    endtask

    // Continues from test_startup at sample 384: frame 4 pixel 0, streaming.
    task automatic test_conversion565();
        logic [15:0] din  [4] = '{16'hF800, 16'h07E0, 16'hFFFF, 16'h001F};
        logic [23:0] dout [4] = '{24'hF80000, 24'h00FC00, 24'hF8FCF8, 24'h0000F8};
        for (int i = 0; i < 4; i++) begin
            b0.fifo_data_in = din[i];
            #1;
            n_cmp++; if (b0.fifo_read_en !== 1'b1) begin n_bad++; $display("FAIL c565_rd i=%0d got %b want 1", i, b0.fifo_read_en); end
            @(negedge clk);
            n_cmp++; if (b0.RGBchannel !== dout[i]) begin n_bad++; $display("FAIL c565_rgb in=%h got %h want %h", din[i], b0.RGBchannel, dout[i]); end
        end
        b0.fifo_data_in = 16'hF800;
        repeat (5) @(negedge clk);
        n_cmp++; if (b0.RGBchannel !== 24'h0 || b0.dataEnable !== 1'b0) begin n_bad++; $display("FAIL c565_porch rgb %h de %b want 0/0", b0.RGBchannel, b0.dataEnable); end
    endtask

    // RGB888 pass-through and active-high sync on dut1 (streams from frame 2).
    task automatic test_conversion888();
        b1.fifo_empty   = 1'b0;
        b1.fifo_data_in = 24'h123456;
        rst1 = 1'b1;
        @(negedge clk);
        n_cmp++; if (b1.hsync !== 1'b0 || b1.vsync !== 1'b0) begin n_bad++; $display("FAIL c888_reset_sync hs %b vs %b want 0/0", b1.hsync, b1.vsync); end
        @(negedge clk);
        rst1 = 1'b0;
        repeat (11) @(negedge clk);
        n_cmp++; if (b1.hsync !== 1'b1) begin n_bad++; $display("FAIL c888_hs_active got %b want 1", b1.hsync); end
        repeat (117) @(negedge clk);
        n_cmp++; if (b1.fifo_read_en !== 1'b1) begin n_bad++; $display("FAIL c888_rd got %b want 1", b1.fifo_read_en); end
        @(negedge clk);
        n_cmp++; if (b1.RGBchannel !== 24'h123456) begin n_bad++; $display("FAIL c888_rgb got %h want 123456", b1.RGBchannel); end
        b1.fifo_data_in = 24'hABCDEF;
        @(negedge clk);
        n_cmp++; if (b1.RGBchannel !== 24'hABCDEF) begin n_bad++; $display("FAIL c888_rgb2 got %h want abcdef", b1.RGBchannel); end
    endtask

    // FIFO runs dry after 20 pops in frame 3; frame 4 realigns; frame 5 clean.
    task automatic test_underflow();
        int pops = 0;
        int red = 0;
        int good = 0;
        int pops4 = 0;
        int pops5 = 0;
        b0.fifo_empty   = 1'b0;
        b0.fifo_data_in = 16'hF800;
        rel0();
        repeat (256) @(negedge clk);
        for (int k = 256; k < 384; k++) begin
            b0.fifo_empty = (pops >= 20);
            #1;
            if (b0.fifo_read_en === 1'b1) pops++;
            @(negedge clk);
            if (b0.RGBchannel === 24'hFF0000) red++;
            if (b0.RGBchannel === 24'hF80000) good++;
        end
        n_cmp++; if (pops != 20) begin n_bad++; $display("FAIL uf_pops got %0d want 20", pops); end
        n_cmp++; if (red != 12) begin n_bad++; $display("FAIL uf_red_px got %0d want 12", red); end
        n_cmp++; if (good != 20) begin n_bad++; $display("FAIL uf_good_px got %0d want 20", good); end
        n_cmp++; if (b0.underflow_count !== 16'd12) begin n_bad++; $display("FAIL uf_count got %0d want 12", b0.underflow_count); end
        n_cmp++; if (b0.sync_lost !== 1'b1) begin n_bad++; $display("FAIL uf_lost got %b want 1", b0.sync_lost); end
        b0.fifo_empty = 1'b0;
        for (int k = 384; k < 512; k++) begin
            #1;
            if (b0.fifo_read_en === 1'b1) pops4++;
            @(negedge clk);
        end
        for (int k = 512; k < 640; k++) begin
            #1;
            if (b0.fifo_read_en === 1'b1) pops5++;
            @(negedge clk);
        end
        n_cmp++; if (pops4 != 0) begin n_bad++; $display("FAIL uf_align_pops got %0d want 0", pops4); end
        n_cmp++; if (pops5 != 32) begin n_bad++; $display("FAIL uf_restream_pops got %0d want 32", pops5); end
        n_cmp++; if (b0.underflow_count !== 16'd12) begin n_bad++; $display("FAIL uf_count_hold got %0d want 12", b0.underflow_count); end
        n_cmp++; if (b0.sync_lost !== 1'b1) begin n_bad++; $display("FAIL uf_lost_hold got %b want 1", b0.sync_lost); end
    endtask

    // From sample 640 (streaming, count 12): reset at h=5,v=2, then full restart.
    task automatic test_reset_midframe();
        int pops = 0;
        repeat (37) @(negedge clk);
        n_cmp++; if (b0.pixel_x !== 12'd5 || b0.pixel_y !== 12'd2 || b0.fifo_read_en !== 1'b1) begin
            n_bad++; $display("FAIL rmf_pre x %0d y %0d rd %b want 5 2 1", b0.pixel_x, b0.pixel_y, b0.fifo_read_en);
        end
        #2;
        rst0 = 1'b1;
        #1;
        n_cmp++; if (b0.pixel_x !== 12'd0 || b0.pixel_y !== 12'd0) begin n_bad++; $display("FAIL rmf_xy got %0d %0d want 0 0", b0.pixel_x, b0.pixel_y); end
        n_cmp++; if (b0.fifo_read_en !== 1'b0) begin n_bad++; $display("FAIL rmf_rd got %b want 0", b0.fifo_read_en); end
        n_cmp++; if (b0.hsync !== 1'b1 || b0.vsync !== 1'b1) begin n_bad++; $display("FAIL rmf_sync got %b %b want 1 1", b0.hsync, b0.vsync); end
        n_cmp++; if (b0.dataEnable !== 1'b0 || b0.frame_start !== 1'b0) begin n_bad++; $display("FAIL rmf_de_fs got %b %b want 0 0", b0.dataEnable, b0.frame_start); end
        n_cmp++; if (b0.RGBchannel !== 24'h0) begin n_bad++; $display("FAIL rmf_rgb got %h want 0", b0.RGBchannel); end
        n_cmp++; if (b0.underflow_count !== 16'h0 || b0.sync_lost !== 1'b0) begin n_bad++; $display("FAIL rmf_stats got %0d %b want 0 0", b0.underflow_count, b0.sync_lost); end
        @(negedge clk);
        rst0 = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if (b0.fifo_read_en === 1'b1) pops++;
            @(negedge clk);
        end
        n_cmp++; if (pops != 0) begin n_bad++; $display("FAIL rmf_blank_pops got %0d want 0", pops); end
        n_cmp++; if (b0.fifo_read_en !== 1'b1) begin n_bad++; $display("FAIL rmf_restream got %b want 1", b0.fifo_read_en); end
    endtask

    // 259x259 raster, 65536 visible pixels: one fully empty frame saturates the count.
    task automatic test_saturation();
        b2.fifo_empty   = 1'b0;
        b2.fifo_data_in = 16'h0000;
        rst2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        repeat (67081) @(negedge clk);
        b2.fifo_empty = 1'b1;
        #1;
        n_cmp++; if (b2.fifo_read_en !== 1'b0) begin n_bad++; $display("FAIL sat_rd_empty got %b want 0", b2.fifo_read_en); end
        @(negedge clk);
        n_cmp++; if (b2.underflow_count !== 16'd1) begin n_bad++; $display("FAIL sat_first got %0d want 1", b2.underflow_count); end
        n_cmp++; if (b2.RGBchannel !== 24'hFF0000) begin n_bad++; $display("FAIL sat_rgb got %h want ff0000", b2.RGBchannel); end
        repeat (255) @(negedge clk);
        n_cmp++; if (b2.underflow_count !== 16'd256) begin n_bad++; $display("FAIL sat_line got %0d want 256", b2.underflow_count); end
        repeat (66825) @(negedge clk);
        n_cmp++; if (b2.underflow_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %h want ffff", b2.underflow_count); end
        n_cmp++; if (b2.sync_lost !== 1'b1) begin n_bad++; $display("FAIL sat_lost got %b want 1", b2.sync_lost); end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        rst2 = 1'b1;
        b1.fifo_empty   = 1'b1;
        b1.fifo_data_in = 24'h0;
        b2.fifo_empty   = 1'b1;
        b2.fifo_data_in = 16'h0;
        test_reset();
        test_timing();
        test_startup();
        test_conversion565();
        test_conversion888();
        test_underflow();
        test_reset_midframe();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
